// File: rtl/scroll_if.sv
// scroll_if: control/status bundle between the game-control FSM and the scroll sequencer
interface scroll_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic [1:0] tempo_sel;
  logic [2:0] mode;
  logic       scroll;
  logic       beat;
  logic [5:0] step_count;
  logic       busy;
  logic       song_done;
  modport master (output start, pause, abort, tempo_sel,
                  input mode, scroll, beat, step_count, busy, song_done);
  modport slave (input start, pause, abort, tempo_sel,
                 output mode, scroll, beat, step_count, busy, song_done);
endinterface

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: beat timer and mode/scroll strobe generator for the note-scroll datapath
module scroll_sequencer #(
  parameter int DIV_BASE = 1_000_000,
  parameter int STEPS    = 39,
  parameter int LEADIN   = 4
) (
  input logic    clk,
  input logic    rst,
  scroll_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LEADIN, S_PLAY, S_PAUSED, S_DONE} state_t;
  state_t      state, state_nx, saved, saved_nx, eff;
  logic [23:0] timer, timer_nx, reload;
  logic [7:0]  beat_cnt, beat_nx;
  logic [5:0]  step_count, step_nx;
  logic [2:0]  mode;
  logic        scroll, scroll_nx, beat, beat_p_nx, busy, song_done;
  assign reload = 24'(DIV_BASE >> bus.tempo_sel) - 24'd1;
  // PAUSED runs as whichever state it froze, so resume costs no extra cycle
  assign eff = state == S_PAUSED ? saved : state;
  always_comb begin
    state_nx  = state;
    saved_nx  = saved;
    timer_nx  = timer;
    beat_nx   = beat_cnt;
    step_nx   = step_count;
    scroll_nx = 1'b0;
    beat_p_nx = 1'b0;
    if (bus.abort) begin
      state_nx = S_IDLE;
      step_nx  = '0;
      timer_nx = '0;
      beat_nx  = '0;
    end else if (eff == S_LEADIN || eff == S_PLAY) begin
      if (bus.pause) begin
        state_nx = S_PAUSED;
        saved_nx = eff;
      end else if (timer != '0) begin
        state_nx = eff;
        timer_nx = timer - 24'd1;
      end else begin
        state_nx  = eff;
        timer_nx  = reload;
        beat_p_nx = 1'b1;
        if (eff == S_LEADIN) begin
          beat_nx  = beat_cnt + 8'd1;
          state_nx = beat_cnt + 8'd1 == 8'(LEADIN) ? S_PLAY : S_LEADIN;
        end else begin
          scroll_nx = 1'b1;
          step_nx   = step_count + 6'd1;
          state_nx  = step_count + 6'd1 == 6'(STEPS) ? S_DONE : S_PLAY;
        end
      end
    end else if (state == S_LOAD) begin
      timer_nx = reload;
      beat_nx  = '0;
      state_nx = LEADIN > 0 ? S_LEADIN : S_PLAY;
    end else if (bus.start && (state == S_IDLE || state == S_DONE)) begin
      state_nx = S_LOAD;
      step_nx  = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      saved      <= S_IDLE;
      timer      <= '0;
      beat_cnt   <= '0;
      step_count <= '0;
      mode       <= 3'd0;
      scroll     <= 1'b0;
      beat       <= 1'b0;
      busy       <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      saved      <= saved_nx;
      timer      <= timer_nx;
      beat_cnt   <= beat_nx;
      step_count <= step_nx;
      mode       <= state_nx == S_IDLE ? 3'd0 : state_nx == S_LOAD ? 3'd3 : 3'd4;
      scroll     <= scroll_nx;
      beat       <= beat_p_nx;
      busy       <= state_nx inside {S_LOAD, S_LEADIN, S_PLAY, S_PAUSED};
      song_done  <= state_nx == S_DONE;
    end
  end
  assign bus.mode       = mode;
  assign bus.scroll     = scroll;
  assign bus.beat       = beat;
  assign bus.step_count = step_count;
  assign bus.busy       = busy;
  assign bus.song_done  = song_done;
endmodule
